// File: rtl/alu_md_ctrl_pkg.sv
// Shared ALU / multiply-divide codes, FSM states and the base ALU decoder.
package alu_md_ctrl_pkg;

  // ALU function codes driven on alufn; ALU_NONE marks illegal or unused encodings
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  // Main-decoder instruction classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // func3 codes of the base integer ops
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // func7 codes: base ops, alternate (SUB/SRA) and the RV32M group
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Multiply/divide operations, encoded exactly as their func3
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Sequencer states: IDLE, MUL, DIV, DONE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Base ALU decode; M-extension encodings fall out as ALU_NONE
  function automatic logic [3:0] decode_alufn(input logic [1:0] op,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7);
    logic [3:0] base;
    logic [3:0] res;
    unique case (f3)
      F3_ADD_SUB: base = ALU_ADD;
      F3_SLL:     base = ALU_SLL;
      F3_SLT:     base = ALU_SLT;
      F3_SLTU:    base = ALU_SLTU;
      F3_XOR:     base = ALU_XOR;
      F3_SRL_SRA: base = ALU_SRL;
      F3_OR:      base = ALU_OR;
      default:    base = ALU_AND;
    endcase
    res = ALU_NONE;
    unique case (op)
      ALUOP_ADD: res = ALU_ADD;
      ALUOP_SUB: res = ALU_SUB;
      ALUOP_RTYPE: begin
        if (f7 == F7_BASE) begin
          res = base;
        end else if (f7 == F7_ALT) begin
          if (f3 == F3_ADD_SUB)      res = ALU_SUB;
          else if (f3 == F3_SRL_SRA) res = ALU_SRA;
          else                       res = ALU_NONE;
        end else begin
          res = ALU_NONE;
        end
      end
      default: begin
        if (f3 == F3_SRL_SRA) begin
          if (f7 == F7_BASE)     res = ALU_SRL;
          else if (f7 == F7_ALT) res = ALU_SRA;
          else                   res = ALU_NONE;
        end else begin
          res = base;
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_md_ctrl_mdu_iter.sv
// Iterative multiply/divide datapath working on operand magnitudes.
module mdu_iter
  import alu_md_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic              last,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN:0]     rem_diff;

  // Trial subtraction of the divisor from the left-shifted partial remainder
  assign rem_diff = {rem_q, dvd_q[XLEN-1]} - {1'b0, dvs_q};

  assign last = (cnt_q == LAST_CNT);
  assign prod = prod_q;
  assign quot = dvd_q;
  assign rem  = rem_q;

  // One shift-add or restoring-division step per cycle; load seeds the registers
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d    = '0;
      mcand_d  = {{XLEN{1'b0}}, a_mag};
      mplier_d = b_mag;
      prod_d   = '0;
      dvd_d    = a_mag;
      dvs_d    = b_mag;
      rem_d    = '0;
    end else if (step) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (div_mode) begin
        if (!rem_diff[XLEN]) begin
          rem_d = rem_diff[XLEN-1:0];
          dvd_d = {dvd_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  // Datapath registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: rtl/alu_md_ctrl.sv
// EX-stage ALU decoder with an optional RV32M multiply/divide sequencer.
module alu_md_ctrl
  import alu_md_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic [3:0]      alufn,
  output logic            md_sel,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  assign alufn = decode_alufn(alu_op, func3, func7);

  if (ENABLE_M) begin : g_md
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            fast_q, fast_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] md_result_q, md_result_d;

    logic            is_m_op, start, in_is_div, in_a_signed, in_b_signed, in_div_signed;
    logic            a_neg_in, b_neg_in, div0_in, ovf_in, fast_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            iter_last, iter_step;
    logic [2*XLEN-1:0] iter_prod, prod_fix;
    logic [XLEN-1:0] iter_quot, iter_rem, quot_fix, rem_fix, fixed_result;

    // Operand classification at the start of an M op: signedness, magnitudes, fast paths
    assign is_m_op       = (alu_op == ALUOP_RTYPE) && (func7 == F7_MULDIV);
    assign start         = (state_q == ST_IDLE) && valid && is_m_op && !flush;
    assign in_is_div     = func3[2];
    assign in_div_signed = func3[2] && !func3[0];
    assign in_a_signed   = (!func3[2] && (func3 != MD_MULHU)) || in_div_signed;
    assign in_b_signed   = (func3 == MD_MUL) || (func3 == MD_MULH) || in_div_signed;
    assign a_neg_in      = in_a_signed && rs1[XLEN-1];
    assign b_neg_in      = in_b_signed && rs2[XLEN-1];
    assign a_mag         = a_neg_in ? -rs1 : rs1;
    assign b_mag         = b_neg_in ? -rs2 : rs2;
    assign div0_in       = (rs2 == '0);
    assign ovf_in        = in_div_signed && (rs1 == XMIN) && (rs2 == '1);
    assign fast_in       = in_is_div && (div0_in || ovf_in);
    assign iter_step     = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !flush;

    mdu_iter #(.XLEN(XLEN)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start),
      .clear    (flush),
      .step     (iter_step),
      .div_mode (state_q == ST_DIV),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .last     (iter_last),
      .prod     (iter_prod),
      .quot     (iter_quot),
      .rem      (iter_rem)
    );

    // Sign fix-up of the magnitude results and selection of the requested field
    always_comb begin
      prod_fix     = (a_neg_q ^ b_neg_q) ? -iter_prod : iter_prod;
      quot_fix     = (a_neg_q ^ b_neg_q) ? -iter_quot : iter_quot;
      rem_fix      = a_neg_q ? -iter_rem : iter_rem;
      fixed_result = '0;
      unique case (op_q)
        MD_MUL:                      fixed_result = prod_fix[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: fixed_result = prod_fix[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU: begin
          if (fast_q) fixed_result = div0_q ? '1 : rs1_q;
          else        fixed_result = quot_fix;
        end
        default: begin
          if (fast_q) fixed_result = div0_q ? rs1_q : '0;
          else        fixed_result = rem_fix;
        end
      endcase
    end

    // Next-state logic: flush wins, otherwise start / iterate / report / return to idle
    always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_neg_d     = a_neg_q;
      b_neg_d     = b_neg_q;
      fast_d      = fast_q;
      div0_d      = div0_q;
      rs1_d       = rs1_q;
      md_result_d = md_result_q;
      if (flush) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              op_d    = md_op_e'(func3);
              a_neg_d = a_neg_in;
              b_neg_d = b_neg_in;
              fast_d  = fast_in;
              div0_d  = div0_in;
              rs1_d   = rs1;
              if (fast_in)        state_d = ST_DONE;
              else if (in_is_div) state_d = ST_DIV;
              else                state_d = ST_MUL;
            end
          end
          ST_MUL, ST_DIV: begin
            if (iter_last) state_d = ST_DONE;
          end
          default: begin
            md_result_d = fixed_result;
            state_d     = ST_IDLE;
          end
        endcase
      end
    end

    // Sequencer state and latched operation context
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= ST_IDLE;
        op_q        <= MD_MUL;
        a_neg_q     <= 1'b0;
        b_neg_q     <= 1'b0;
        fast_q      <= 1'b0;
        div0_q      <= 1'b0;
        rs1_q       <= '0;
        md_result_q <= '0;
      end else begin
        state_q     <= state_d;
        op_q        <= op_d;
        a_neg_q     <= a_neg_d;
        b_neg_q     <= b_neg_d;
        fast_q      <= fast_d;
        div0_q      <= div0_d;
        rs1_q       <= rs1_d;
        md_result_q <= md_result_d;
      end
    end

    assign md_done   = (state_q == ST_DONE) && !flush;
    assign md_sel    = md_done;
    assign md_result = md_done ? fixed_result : md_result_q;
    assign stall     = rst_n && !flush &&
                       (((state_q == ST_IDLE) && valid && is_m_op) ||
                        (state_q == ST_MUL) || (state_q == ST_DIV));
  end else begin : g_no_md
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, valid, flush, rs1, rs2};
    assign md_sel        = 1'b0;
    assign stall         = 1'b0;
    assign md_done       = 1'b0;
    assign md_result     = '0;
  end

endmodule
